alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 2, meaning the number of clk1 cycles alu_write is held high per operation (legal 1..15).
REQ-002 SHALL have port clk1, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; reset is asynchronous and active-low.
REQ-004 SHALL have ports req0 / req1, input, 1 each, operation request from requester 0 / 1.
REQ-005 SHALL have ports addr1_0, addr2_0, rd_0 / addr1_1, addr2_1, rd_1, input, 4 each, source and destination register indices per requester.
REQ-006 SHALL have ports func_0 / func_1, input, 3 each, ALU opcode per requester (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 NOT B, 7 INC A).
REQ-007 SHALL have ports memaddr_0 / memaddr_1, input, 8 each, result memory address per requester.
REQ-008 SHALL have ports alu_addr1, alu_addr2, alu_rd (output, 4), alu_func (output, 3), alu_memaddr (output, 8), alu_write (output, 1), driving the shared 8-bit ALU.
REQ-009 SHALL have ports alu_zout (input, 8) and alu_cb (input, 1), ALU result and carry/borrow.
REQ-010 SHALL have ports done0 / done1, output, 1 each, one-cycle completion pulse per requester.
REQ-011 SHALL have ports result (output, 8), result_cb (output, 1), captured ALU result, valid while a done pulse is high.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, GRANT, EXEC, RESP; transitions IDLE->GRANT when req0|req1, GRANT->EXEC always, EXEC->RESP after EXEC_CYCLES cycles in EXEC, RESP->IDLE always.
REQ-014 SHALL arbitrate in IDLE only: single requester wins; both requesting -> grant the requester not granted last (round-robin), tracked by 1-bit last_grant.
REQ-015 SHALL latch the granted requester's addr1, addr2, rd, func, memaddr on the IDLE->GRANT edge; later changes on requester inputs SHALL have no effect on the in-flight operation.
REQ-016 SHALL drive alu_addr1/addr2/rd/func/memaddr from the latched values continuously from GRANT until the next grant (held through RESP and IDLE).
REQ-017 SHALL assert alu_write only in EXEC, for exactly EXEC_CYCLES consecutive cycles per operation; never in IDLE, GRANT or RESP.
REQ-018 SHALL capture alu_zout into result and alu_cb into result_cb on the EXEC->RESP edge; result/result_cb hold until next capture.
REQ-019 SHALL assert done of the granted requester for exactly the one RESP cycle; the other done stays low; last_grant updated on RESP->IDLE.
REQ-020 Latency SHALL be request sampled in IDLE at edge n -> done high in cycle n+2+EXEC_CYCLES (4 cycles with default).
REQ-021 Requester SHALL drop req in the cycle after its done; a req still high in IDLE is treated as a new request (no de-duplication).
REQ-022 A req deasserted after grant SHALL NOT abort the operation; done still pulses.
REQ-023 A request arriving while busy SHALL wait; no request is lost or queued beyond the level of req.
REQ-024 EXEC cycle counter SHALL be 4 bits, cleared on GRANT->EXEC, never wrapping.

Reset
REQ-025 On rst_n low, immediately and regardless of clk1: state IDLE, alu_write 0, done0/done1 0, busy 0, result 0, result_cb 0, all alu_* operand outputs 0, counter 0, last_grant 1 (requester 0 wins first tie).
REQ-026 Reset mid-operation SHALL abort it with no done pulse; after release, a still-high req SHALL be re-arbitrated from IDLE.

Verification
REQ-027 Regbank[i]=i; req0 ADD addr1=3, addr2=5, rd=10, memaddr=225 -> alu_write high 2 cycles, done0 4 cycles after req, result=8, result_cb=0, done1 never high.
REQ-028 req0 and req1 raised same cycle after reset (req0 SUB 10-5, req1 AND 3&8) -> req0 served first, result=5; then req1, result=0; done pulses never overlap.
REQ-029 Both requesters held high continuously for 4 operations -> grants alternate 0,1,0,1; each done exactly one cycle.
REQ-030 Change req0 operand inputs (func 0->2) during EXEC -> alu_func stays 0, result reflects ADD.
REQ-031 Assert rst_n low in second EXEC cycle -> alu_write, busy fall immediately, no done; after release with req1 high -> req1 completes normally.
REQ-032 EXEC_CYCLES=1, single INC A addr1=11 -> alu_write high 1 cycle, done 3 cycles after req, result=12.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared 8-bit ALU.
// Each grant walks IDLE -> GRANT -> EXEC -> RESP. The granted operands are
// latched at grant time and are then presented to the ALU. The ALU result is
// captured when EXEC ends, and the winner gets a one-cycle done pulse.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] addr1_0,
  input  logic [3:0] addr2_0,
  input  logic [3:0] rd_0,
  input  logic [3:0] addr1_1,
  input  logic [3:0] addr2_1,
  input  logic [3:0] rd_1,
  input  logic [2:0] func_0,
  input  logic [2:0] func_1,
  input  logic [7:0] memaddr_0,
  input  logic [7:0] memaddr_1,
  output logic [3:0] alu_addr1,
  output logic [3:0] alu_addr2,
  output logic [3:0] alu_rd,
  output logic [2:0] alu_func,
  output logic [7:0] alu_memaddr,
  output logic       alu_write,
  input  logic [7:0] alu_zout,
  input  logic       alu_cb,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       result_cb,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Counter value on the final EXEC cycle.
  localparam logic [3:0] LP_CNT_LAST = 4'(EXEC_CYCLES - 1);

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       r_grant;
  logic       r_last_grant;
  logic [3:0] r_addr1;
  logic [3:0] r_addr2;
  logic [3:0] r_rd;
  logic [2:0] r_func;
  logic [7:0] r_memaddr;
  logic [7:0] r_result;
  logic       r_result_cb;
  logic       w_pick;
  logic       w_start;

  // Winner if a grant happens now. On a tie, the requester not served last wins.
  always_comb begin
    w_pick = 1'b0;
    if (req0 && req1) begin
      w_pick = ~r_last_grant;
    end else if (req1) begin
      w_pick = 1'b1;
    end
  end

  assign w_start = (r_state == ST_IDLE) && (req0 || req1);

  // State sequencing and EXEC cycle counting.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) r_state <= ST_GRANT;
        end
        ST_GRANT: begin
          r_state <= ST_EXEC;
          r_cnt   <= '0;
        end
        ST_EXEC: begin
          if (r_cnt == LP_CNT_LAST) r_state <= ST_RESP;
          else                      r_cnt   <= r_cnt + 4'd1;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Record the grant, and move it into the round-robin history once the operation retires.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_start) r_grant <= w_pick;
      if (r_state == ST_RESP) r_last_grant <= r_grant;
    end
  end

  // Latch the winner's operands at grant time so later input changes cannot disturb the operation.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_addr1   <= '0;
      r_addr2   <= '0;
      r_rd      <= '0;
      r_func    <= '0;
      r_memaddr <= '0;
    end else if (w_start) begin
      r_addr1   <= w_pick ? addr1_1   : addr1_0;
      r_addr2   <= w_pick ? addr2_1   : addr2_0;
      r_rd      <= w_pick ? rd_1      : rd_0;
      r_func    <= w_pick ? func_1    : func_0;
      r_memaddr <= w_pick ? memaddr_1 : memaddr_0;
    end
  end

  // Capture the ALU result on the last EXEC cycle, and hold it until the next capture.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_result_cb <= 1'b0;
    end else if ((r_state == ST_EXEC) && (r_cnt == LP_CNT_LAST)) begin
      r_result    <= alu_zout;
      r_result_cb <= alu_cb;
    end
  end

  assign alu_addr1   = r_addr1;
  assign alu_addr2   = r_addr2;
  assign alu_rd      = r_rd;
  assign alu_func    = r_func;
  assign alu_memaddr = r_memaddr;
  assign alu_write   = (r_state == ST_EXEC);
  assign busy        = (r_state != ST_IDLE);
  assign done0       = (r_state == ST_RESP) && !r_grant;
  assign done1       = (r_state == ST_RESP) &&  r_grant;
  assign result      = r_result;
  assign result_cb   = r_result_cb;

endmodule
